step_generator: RTL

Generates up/down step pulses on `signal`/`nsignal` that drive a pulse counter from its current position to a commanded target at a programmable rate, tracking the position it has emitted. Sits upstream of the up/down pulse counter: its two outputs connect one-to-one to the counter's `signal`/`nsignal` inputs, and its `position` output mirrors the value the counter will reach. Host logic loads a target and a rate, then waits for `done`.

---
 rtl/step_generator_pkg.sv | 21 ++
 rtl/step_generator_divider.sv | 27 ++
 rtl/step_generator.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/step_generator_pkg.sv
// Shared definitions for step_generator: FSM states, step direction and ramp factors.
package step_generator_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam logic [2:0] RAMP_X4 = 3'd4;
   localparam logic [2:0] RAMP_X2 = 3'd2;
   localparam logic [2:0] RAMP_X1 = 3'd1;

   function automatic logic [2:0] ramp_max(input logic [2:0] a, input logic [2:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/step_generator_divider.sv
// step_divider: interval counter; o_tc is high in the cycle the count reaches the interval-1 value.
module step_divider #(
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             i_reset,
   input  logic             i_clear,
   input  logic             i_enable,
   input  logic [WIDTH-1:0] i_interval_m1,
   output logic             o_tc
);

   logic [WIDTH-1:0] r_count;

   assign o_tc = i_enable && (r_count == i_interval_m1);

   always_ff @(posedge clk) begin
      if (i_reset || i_clear) begin
         r_count <= '0;
      end else if (o_tc) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/step_generator.sv
// step_generator: emits up/down step pulses toward a clamped target at a programmable rate.
// Optional trapezoidal ramp when STEP_GENERATOR_RAMP_EN is defined.
module step_generator
   import step_generator_pkg::*;
#(
   parameter int RESOLUTION    = 64,
   parameter int DIVIDER_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic signed [RESOLUTION-1:0] target,
   input  logic signed [RESOLUTION-1:0] position_max,
   input  logic signed [RESOLUTION-1:0] position_min,
   input  logic [DIVIDER_WIDTH-1:0]     rate,
   input  logic                         load,
   input  logic                         abort,
   output logic                         signal,
   output logic                         nsignal,
   output logic signed [RESOLUTION-1:0] position,
   output logic                         busy,
   output logic                         done,
   output logic                         clipped
);

   localparam int CW = DIVIDER_WIDTH + 2;
   localparam logic [RESOLUTION-1:0] POS_ONE = RESOLUTION'(1);

   state_t r_state, w_state_next;

   logic signed [RESOLUTION-1:0] r_position, r_tgt, w_tgt_eff;
   logic [DIVIDER_WIDTH-1:0]     r_rate;
   logic                         r_clipped, r_start, r_signal, r_nsignal;
   logic                         w_clip, w_accept, w_tick, w_dir, w_at_tgt, w_div_en, w_div_clr;
   logic [CW-1:0]                w_interval_m1;

   // Load is taken in IDLE or in the DONE cycle; abort always wins over load.
   assign w_accept = load && !abort && !r_start && (r_state != RUN);
   assign w_at_tgt = (r_position == r_tgt);
   assign w_dir    = (r_tgt > r_position) ? DIR_UP : DIR_DOWN;
   assign w_div_en = (r_state == RUN) && !w_at_tgt;
   assign w_div_clr = abort || (r_state != RUN);

   always_comb begin
      w_tgt_eff = target;
      if (target < position_min) w_tgt_eff = position_min;
      if (target > position_max) w_tgt_eff = position_max;
      w_clip = (w_tgt_eff != target);
      if (position_min > position_max) begin
         w_tgt_eff = r_position;
         w_clip    = 1'b1;
      end
   end

`ifdef STEP_GENERATOR_RAMP_EN
   logic [1:0]            r_pulse_idx;
   logic [2:0]            w_start_f, w_stop_f, w_factor;
   logic [RESOLUTION-1:0] w_dist;
   logic [CW-1:0]         w_rate_p1, w_interval;

   assign w_rate_p1 = CW'(r_rate) + CW'(1);
   assign w_dist    = (w_dir == DIR_UP) ? (r_tgt - r_position) : (r_position - r_tgt);

   always_comb begin
      w_start_f = RAMP_X1;
      if (r_pulse_idx == 2'd0)      w_start_f = RAMP_X4;
      else if (r_pulse_idx == 2'd1) w_start_f = RAMP_X2;
      w_stop_f = RAMP_X1;
      if (w_dist == POS_ONE)                w_stop_f = RAMP_X4;
      else if (w_dist == RESOLUTION'(2))    w_stop_f = RAMP_X2;
      w_factor   = ramp_max(w_start_f, w_stop_f);
      w_interval = w_rate_p1;
      if (w_factor == RAMP_X4)      w_interval = w_rate_p1 << 2;
      else if (w_factor == RAMP_X2) w_interval = w_rate_p1 << 1;
   end

   assign w_interval_m1 = w_interval - CW'(1);

   // Pulse index only needs to distinguish the first, second and later pulses.
   always_ff @(posedge clk) begin
      if (reset || w_accept) begin
         r_pulse_idx <= 2'd0;
      end else if (w_tick && (r_pulse_idx != 2'd2)) begin
         r_pulse_idx <= r_pulse_idx + 2'd1;
      end
   end
`else
   assign w_interval_m1 = CW'(r_rate);
`endif

   step_divider #(
      .WIDTH(CW)
   ) u_divider (
      .clk          (clk),
      .i_reset      (reset),
      .i_clear      (w_div_clr),
      .i_enable     (w_div_en),
      .i_interval_m1(w_interval_m1),
      .o_tc         (w_tick)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   // RUN leaves once the final pulse is visible, so done follows the last pulse by one cycle.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (r_start) w_state_next = w_at_tgt ? DONE : RUN;
         RUN:     if (w_at_tgt) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
      if (abort) w_state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tgt     <= '0;
         r_rate    <= '0;
         r_clipped <= 1'b0;
         r_start   <= 1'b0;
      end else begin
         r_start <= w_accept;
         if (w_accept) begin
            r_tgt     <= w_tgt_eff;
            r_rate    <= rate;
            r_clipped <= w_clip;
         end
      end
   end

   // A tick on the abort edge still emits its pulse and is counted.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_signal   <= 1'b0;
         r_nsignal  <= 1'b0;
         r_position <= '0;
      end else begin
         r_signal  <= w_tick && (w_dir == DIR_UP);
         r_nsignal <= w_tick && (w_dir == DIR_DOWN);
         if (w_tick) begin
            r_position <= (w_dir == DIR_UP) ? r_position + POS_ONE : r_position - POS_ONE;
         end
      end
   end

   assign signal   = r_signal;
   assign nsignal  = r_nsignal;
   assign position = r_position;
   assign busy     = (r_state == RUN);
   assign done     = (r_state == DONE);
   assign clipped  = r_clipped;

endmodule
